alu_share_arbiter: RTL and testbench

- Shares one combinational alu_32bit instance between two requesters: the execute stage (req0) and the branch/address unit (req1).
- Arbitrates with round-robin or fixed priority and drives the ALU operands and op code.
- Captures result and NZCV into a one-entry response register per requester, with valid/ready on both sides.
- Supports a lock so a requester can hold the ALU for back-to-back operations.

---
 rtl/alu_share_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters
// (req0 = execute stage, req1 = branch/address unit).
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   reqN_valid/ready/op/a/b/lock      request channels (N = 0, 1)
//   rspN_valid/ready/result/flags     one-entry registered response per requester
//   alu_ctrl, alu_a, alu_b            drive to the shared ALU
//   alu_result, alu_flags             combinational ALU outputs, flags {N,Z,C,V}
//
// Optional build macro ALU_ARB_PERF_EN adds perf_grant0, perf_grant1 and
// perf_conflict (32-bit wrapping counters).
//
// Arbitration is round-robin (FIXED_PRIO=0) or req0-first (FIXED_PRIO=1). A
// requester that transfers with lock=1 keeps the ALU until it drops lock or
// has taken LOCK_MAX further grants in the locked state.

`ifndef ALU_ADD
  // Fallback when define.sv is not compiled in; must match its ADD encoding.
  `define ALU_ADD 5'b00000
`endif

module alu_share_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned LOCK_MAX   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [4:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req0_lock,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [4:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic            req1_lock,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic [3:0]      rsp0_flags,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic [3:0]      rsp1_flags,
  output logic [4:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      alu_flags
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]     perf_grant0,
  output logic [31:0]     perf_grant1,
  output logic [31:0]     perf_conflict
`endif
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0] LockMaxC = CntW'(LOCK_MAX);

  typedef enum logic [1:0] {StArb, StLock0, StLock1} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;

  logic elig0, elig1;
  logic grant0, grant1;
  logic xfer, xfer_lock, win;

  // A requester may go only if its response slot is free or draining now.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state_q)
      StLock0: grant0 = elig0;
      StLock1: grant1 = elig1;
      default: begin
        if (elig0 && elig1) begin
          if (FIXED_PRIO != 0 || !rr_q) grant0 = 1'b1;
          else                          grant1 = 1'b1;
        end else begin
          grant0 = elig0;
          grant1 = elig1;
        end
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign xfer      = grant0 | grant1;
  assign win       = grant1;
  assign xfer_lock = grant0 ? req0_lock : req1_lock;

  always_comb begin
    alu_ctrl = `ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (grant0) begin
      alu_ctrl = req0_op;
      alu_a    = req0_a;
      alu_b    = req0_b;
    end else if (grant1) begin
      alu_ctrl = req1_op;
      alu_a    = req1_a;
      alu_b    = req1_b;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_cnt_d = lock_cnt_q;
    if (xfer) begin
      unique case (state_q)
        StArb: begin
          rr_d = ~win;
          if (xfer_lock) begin
            state_d    = win ? StLock1 : StLock0;
            lock_cnt_d = CntW'(1);
          end
        end
        default: begin
          if (xfer_lock && (lock_cnt_q < LockMaxC)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            // Voluntary or forced release: the other side gets priority next.
            state_d    = StArb;
            lock_cnt_d = '0;
            rr_d       = ~win;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StArb;
      rr_q       <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Refill wins over drain so a port sustains one result per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_flags  <= '0;
    end else if (grant0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_flags  <= alu_flags;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_flags  <= '0;
    end else if (grant1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_flags  <= alu_flags;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant0) perf_grant0 <= perf_grant0 + 32'd1;
      if (grant1) perf_grant1 <= perf_grant1 + 32'd1;
      // At most one grant per cycle, so every both-valid cycle is contested.
      if (req0_valid && req1_valid) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter (FIXED_PRIO=0, LOCK_MAX=8) with a
// small behavioural ALU (ADD/SUB with {N,Z,C,V}) on the shared ALU port.
// Inputs change 1 time unit after a rising edge; outputs are checked 3 units
// after the edge.

module tb_alu_share_arbiter;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_lock;
  logic [4:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_lock;
  logic [4:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_flags;
`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .XLEN       (32),
    .FIXED_PRIO (0),
    .LOCK_MAX   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_lock   (req0_lock),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_lock   (req1_lock),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_flags  (rsp0_flags),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_flags  (rsp1_flags),
    .alu_ctrl    (alu_ctrl),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant0   (perf_grant0),
    .perf_grant1   (perf_grant1),
    .perf_conflict (perf_conflict)
`endif
  );

  // Behavioural ALU: SUB computes a + ~b + 1, C = no borrow.
  logic [32:0] wide;
  logic        ovf;
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    if (alu_ctrl == OP_SUB) begin
      wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      ovf  = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
    end else begin
      wide = {1'b0, alu_a} + {1'b0, alu_b};
      ovf  = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
    end
    alu_result = wide[31:0];
    alu_flags  = {wide[31], (wide[31:0] == 32'd0), wide[32], ovf};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  logic        exp_port;
  logic [31:0] exp_res;
  logic [3:0]  exp_flg;
  logic        exp_g0;

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0; req0_op = OP_ADD; req0_a = '0; req0_b = '0; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_op = OP_ADD; req1_a = '0; req1_b = '0; req1_lock = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    exp_port   = 1'b0;
    exp_res    = '0;
    exp_flg    = '0;

    // Reset state
    #3;
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_flags", rsp1_flags, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("idle_alu_ctrl", alu_ctrl, OP_ADD);
    chk("idle_alu_a", alu_a, 0);
    step();
    rst_n = 1'b1;

    // Single ADD with signed overflow
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
    settle();
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    chk("t1_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("t1_alu_b", alu_b, 32'd1);
    step();
    req0_valid = 1'b0;
    settle();
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_rsp0_result", rsp0_result, 32'h8000_0000);
    chk("t1_rsp0_flags", rsp0_flags, 4'b1001);
    step();
    settle();
    chk("t1_rsp0_drained", rsp0_valid, 0);

    // Reset again so round-robin starts from req0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();

    // Round-robin: both valid, grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h10 + i; req0_b = 32'd1;
      req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'h200 + i - 1; req1_b = 32'h200;
      settle();
      chk("rr_grant0", req0_ready, (i % 2) == 0);
      chk("rr_grant1", req1_ready, (i % 2) == 1);
      if (i > 0) begin
        if (exp_port == 1'b0) begin
          chk("rr_rsp0_valid", rsp0_valid, 1);
          chk("rr_rsp0_result", rsp0_result, exp_res);
          chk("rr_rsp0_flags", rsp0_flags, exp_flg);
        end else begin
          chk("rr_rsp1_valid", rsp1_valid, 1);
          chk("rr_rsp1_result", rsp1_result, exp_res);
          chk("rr_rsp1_flags", rsp1_flags, exp_flg);
        end
      end
      exp_port = ((i % 2) == 1);
      exp_res  = ((i % 2) == 0) ? 32'h11 + i : i - 1;
      exp_flg  = ((i % 2) == 0) ? 4'b0000 : ((i == 1) ? 4'b0110 : 4'b0010);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    chk("rr_last_rsp1_valid", rsp1_valid, 1);
    chk("rr_last_rsp1_result", rsp1_result, 32'd2);
    chk("rr_last_rsp1_flags", rsp1_flags, 4'b0010);
    step();

    // Full rsp1 slot blocks req1; req0 is served meanwhile
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 32'd9; req1_b = 32'd5;
    settle();
    chk("t3_fill_ready1", req1_ready, 1);
    step();
    req1_a     = 32'd5;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("t3_req1_blocked", req1_ready, 0);
      chk("t3_req0_served", req0_ready, 1);
      chk("t3_rsp1_held", rsp1_result, 32'd4);
      step();
    end
    settle();
    chk("t3_rsp0_valid", rsp0_valid, 1);
    chk("t3_rsp0_result", rsp0_result, 32'd3);
    rsp1_ready = 1'b1;
    #1;
    chk("t3_req1_unblocked", req1_ready, 1);
    chk("t3_req0_waits", req0_ready, 0);
    chk("t3_alu_ctrl_sub", alu_ctrl, OP_SUB);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    chk("t3_rsp1_valid", rsp1_valid, 1);
    chk("t3_rsp1_result", rsp1_result, 32'd0);
    chk("t3_rsp1_flags", rsp1_flags, 4'b0110);
    step();

    // Lock: entry grant plus 8 locked grants to req0, forced release, then ARB
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd2; req1_b = 32'd2;
    for (int k = 0; k < 12; k++) begin
      req0_lock = (k < 9);
      settle();
      exp_g0 = (k <= 8) || (k == 10);
      chk("lock_grant0", req0_ready, exp_g0);
      chk("lock_grant1", req1_ready, !exp_g0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_lock  = 1'b0;
    step();

    // Async reset out of LOCK1 with a held response
    req1_valid = 1'b1; req1_lock = 1'b1; req1_op = OP_ADD; req1_a = 32'd3; req1_b = 32'd4;
    settle();
    chk("t5_req1_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    req1_lock  = 1'b0;
    settle();
    chk("t5_rsp1_valid", rsp1_valid, 1);
    chk("t5_rsp1_result", rsp1_result, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("t5_async_rsp1_valid", rsp1_valid, 0);
    chk("t5_async_rsp1_result", rsp1_result, 0);
    rst_n = 1'b1;
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    chk("t5_post_rst_grant0", req0_ready, 1);
    chk("t5_post_rst_grant1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

`ifdef ALU_ARB_PERF_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int p = 0; p < 5; p++) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    settle();
    chk("perf_conflict", perf_conflict, 32'd5);
    chk("perf_grant_sum", perf_grant0 + perf_grant1, 32'd5);
    chk("perf_grant0", perf_grant0, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
